// File: rtl/btn_pkg.sv
// btn_pkg
//   Shared constants and helpers for the button debounce / auto-repeat block.
//   Holds the default parameter values used by btn_debounce_rpt and btn_chan,
//   plus the width function every counter uses to size itself.
package btn_pkg;

  localparam int DEF_NCH    = 3;
  localparam int DEF_DIV    = 1200000;
  localparam int DEF_STABLE = 3;
  localparam int DEF_LONG   = 40;
  localparam int DEF_RPT    = 8;

  // Ceiling log2 with a floor of one bit. A counter that must hold the values
  // 0..m is sized with clog2w(m + 1).
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// btn_chan
//   One button channel: two-flop synchroniser, stability (debounce) counter,
//   hold counter for auto-repeat, and the registered event pulses.
//
// Ports
//   CLK      in   system clock
//   RST      in   asynchronous active-low reset
//   tick     in   shared sample tick, one CLK wide
//   nb       in   raw active-low button input, asynchronous to CLK
//   blevel   out  debounced pressed state (1 = pressed)
//   bpress   out  one-CLK pulse when a press is accepted
//   brelease out  one-CLK pulse when a release is accepted
//   brepeat  out  one-CLK auto-repeat pulse while held
module btn_chan
  import btn_pkg::*;
#(
  parameter int STABLE = DEF_STABLE,
  parameter int LONG   = DEF_LONG,
  parameter int RPT    = DEF_RPT
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic nb,
  output logic blevel,
  output logic bpress,
  output logic brelease,
  output logic brepeat
);

  localparam int SW = clog2w(STABLE + 1);
  localparam int HW = clog2w(LONG + 1);

  logic          sync1;
  logic          sync2;
  logic          sample;
  logic [SW-1:0] stab;
  logic [SW-1:0] stab_inc;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_inc;
  logic          accept;

  // Synchroniser resets to 1 so a released button is what we see after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= nb;
      sync2 <= sync1;
    end
  end

  assign sample   = ~sync2;
  assign stab_inc = stab + 1'b1;
  assign hold_inc = hold + 1'b1;

  // A level change is accepted on the tick whose increment reaches STABLE.
  assign accept = tick && (sample != blevel) && (stab_inc == SW'(STABLE));

  // Debounce: differing samples count up, a matching sample restarts the run.
  // The press/release pulse is registered together with the new level so it
  // lines up with the first cycle the new level is visible.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stab     <= '0;
      blevel   <= 1'b0;
      bpress   <= 1'b0;
      brelease <= 1'b0;
    end else begin
      bpress   <= 1'b0;
      brelease <= 1'b0;
      if (tick) begin
        if (sample == blevel) begin
          stab <= '0;
        end else if (accept) begin
          stab     <= '0;
          blevel   <= sample;
          bpress   <= sample;
          brelease <= ~sample;
        end else begin
          stab <= stab_inc;
        end
      end
    end
  end

  // Hold counter: restarts on every accepted edge, so an accept always wins
  // over a repeat that would land on the same tick. After the first repeat it
  // reloads LONG-RPT so later repeats come every RPT ticks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold    <= '0;
      brepeat <= 1'b0;
    end else begin
      brepeat <= 1'b0;
      if (tick) begin
        if (accept) begin
          hold <= '0;
        end else if (blevel) begin
          if (hold_inc == HW'(LONG)) begin
            brepeat <= 1'b1;
            hold    <= HW'(LONG - RPT);
          end else begin
            hold <= hold_inc;
          end
        end
      end
    end
  end

endmodule

// File: rtl/btn_debounce_rpt.sv
// btn_debounce_rpt
//   Multi-channel button debouncer with press/release pulses and auto-repeat.
//   A shared divider produces the sample tick; each channel is a btn_chan.
//
// Ports
//   CLK      in   system clock
//   RST      in   asynchronous active-low reset
//   nBIN     in   [NCH] raw active-low buttons, asynchronous to CLK
//   BLEVEL   out  [NCH] debounced pressed state (1 = pressed)
//   BPRESS   out  [NCH] one-CLK pulse on accepted press
//   BRELEASE out  [NCH] one-CLK pulse on accepted release
//   BREPEAT  out  [NCH] one-CLK auto-repeat pulse while held
module btn_debounce_rpt
  import btn_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int DIV    = DEF_DIV,
  parameter int STABLE = DEF_STABLE,
  parameter int LONG   = DEF_LONG,
  parameter int RPT    = DEF_RPT
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] nBIN,
  output logic [NCH-1:0] BLEVEL,
  output logic [NCH-1:0] BPRESS,
  output logic [NCH-1:0] BRELEASE,
  output logic [NCH-1:0] BREPEAT
);

  localparam int TW = clog2w(DIV);

  logic [TW-1:0] tcnt;
  logic          tick;

  // With DIV=1 the counter sits at 0 and tick is high every cycle.
  assign tick = (tcnt == TW'(DIV - 1));

  // Sample-tick divider, 0..DIV-1 wrapping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    btn_chan #(
      .STABLE (STABLE),
      .LONG   (LONG),
      .RPT    (RPT)
    ) u_chan (
      .CLK      (CLK),
      .RST      (RST),
      .tick     (tick),
      .nb       (nBIN[i]),
      .blevel   (BLEVEL[i]),
      .bpress   (BPRESS[i]),
      .brelease (BRELEASE[i]),
      .brepeat  (BREPEAT[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// tb_btn_debounce_rpt
//   Directed bench for btn_debounce_rpt with DIV=4, STABLE=3, LONG=6, RPT=2.
//   cyc counts rising edges since reset release; ticks land on cyc % 4 == 0.
//   Inputs change 2 time units after a tick edge, so an acceptance happens
//   on the 3rd tick edge after that change (change at T -> accept at T+12).
module tb_btn_debounce_rpt;

  logic       CLK;
  logic       RST;
  logic [2:0] nBIN;
  logic [2:0] BLEVEL;
  logic [2:0] BPRESS;
  logic [2:0] BRELEASE;
  logic [2:0] BREPEAT;

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;

  int pressCnt[3] = '{0, 0, 0};
  int relCnt[3]   = '{0, 0, 0};
  int rptCnt[3]   = '{0, 0, 0};
  int pressAt[3]  = '{-1, -1, -1};
  int relAt[3]    = '{-1, -1, -1};
  int rptLog[$];

  int pressBase;
  int relBase;

  btn_debounce_rpt #(
    .NCH    (3),
    .DIV    (4),
    .STABLE (3),
    .LONG   (6),
    .RPT    (2)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .nBIN     (nBIN),
    .BLEVEL   (BLEVEL),
    .BPRESS   (BPRESS),
    .BRELEASE (BRELEASE),
    .BREPEAT  (BREPEAT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Pulse monitor: counts every high cycle of each pulse and records when.
  always @(negedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        if (BPRESS[i]) begin
          pressCnt[i] = pressCnt[i] + 1;
          pressAt[i]  = cyc;
        end
        if (BRELEASE[i]) begin
          relCnt[i] = relCnt[i] + 1;
          relAt[i]  = cyc;
        end
        if (BREPEAT[i]) begin
          rptCnt[i] = rptCnt[i] + 1;
          if (i == 2) rptLog.push_back(cyc);
        end
      end
    end
  end

  // Hard stop in case something goes badly wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] value);
    nBIN = value;
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #2;
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  initial begin
    RST = 1'b0;
    applyStimulus(3'b111);

    // Reset state.
    repeat (3) stepCycle();
    checkOutput("rst_blevel",   int'(BLEVEL),   0);
    checkOutput("rst_bpress",   int'(BPRESS),   0);
    checkOutput("rst_brelease", int'(BRELEASE), 0);
    checkOutput("rst_brepeat",  int'(BREPEAT),  0);
    RST = 1'b1;
    cyc = 0;

    // Clean press on channel 0.
    stepTo(4);
    applyStimulus(3'b110);
    stepTo(15);
    checkOutput("press0_before_level", int'(BLEVEL), 0);
    stepTo(16);
    checkOutput("press0_level", int'(BLEVEL), 1);
    checkOutput("press0_pulse", int'(BPRESS), 1);
    stepTo(17);
    checkOutput("press0_pulse_end", int'(BPRESS), 0);
    stepTo(24);
    applyStimulus(3'b111);
    checkOutput("press0_count", pressCnt[0], 1);
    checkOutput("press0_at", pressAt[0], 16);
    checkOutput("press0_others_quiet", pressCnt[1] + pressCnt[2], 0);
    stepTo(40);
    checkOutput("rel0_count", relCnt[0], 1);
    checkOutput("rel0_at", relAt[0], 36);
    checkOutput("rel0_no_repeat", rptCnt[0], 0);
    checkOutput("rel0_level", int'(BLEVEL), 0);

    // Bounce on channel 1: toggled every tick, never stable for 3 ticks.
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i % 2 == 0) ? 3'b101 : 3'b111);
      stepTo(cyc + 4);
    end
    applyStimulus(3'b111);
    stepTo(120);
    checkOutput("bounce1_press", pressCnt[1], 0);
    checkOutput("bounce1_release", relCnt[1], 0);
    checkOutput("bounce1_repeat", rptCnt[1], 0);
    checkOutput("bounce1_level", int'(BLEVEL), 0);

    // Long hold on channel 2, released so the release lands on a repeat tick.
    applyStimulus(3'b011);
    stepTo(134);
    checkOutput("hold2_press_at", pressAt[2], 132);
    checkOutput("hold2_level", int'(BLEVEL), 4);
    stepTo(208);
    applyStimulus(3'b111);
    stepTo(240);
    checkOutput("hold2_repeat_count", rptLog.size(), 8);
    for (int j = 0; j < 8; j++) begin
      if (j < rptLog.size()) checkOutput($sformatf("hold2_repeat_at%0d", j), rptLog[j], 156 + 8 * j);
    end
    checkOutput("rel2_count", relCnt[2], 1);
    checkOutput("rel2_at", relAt[2], 220);
    checkOutput("rel2_repeat_total", rptCnt[2], 8);
    checkOutput("rel2_level", int'(BLEVEL), 0);

    // Re-press channel 2: first repeat needs a full LONG again.
    stepTo(260);
    applyStimulus(3'b011);
    stepTo(300);
    applyStimulus(3'b111);
    stepTo(320);
    checkOutput("repress2_press_at", pressAt[2], 272);
    checkOutput("repress2_repeat_count", rptLog.size(), 10);
    if (rptLog.size() >= 10) begin
      checkOutput("repress2_first_repeat", rptLog[8], 296);
      checkOutput("repress2_second_repeat", rptLog[9], 304);
    end
    checkOutput("repress2_rel_at", relAt[2], 312);

    // Reset while channel 0 is held.
    applyStimulus(3'b110);
    stepTo(340);
    checkOutput("midhold0_level", int'(BLEVEL), 1);
    pressBase = pressCnt[0];
    relBase   = relCnt[0];
    RST = 1'b0;
    #1;
    checkOutput("midrst_async_level", int'(BLEVEL), 0);
    stepCycle();
    stepCycle();
    checkOutput("midrst_level",   int'(BLEVEL),   0);
    checkOutput("midrst_press",   int'(BPRESS),   0);
    checkOutput("midrst_release", int'(BRELEASE), 0);
    checkOutput("midrst_repeat",  int'(BREPEAT),  0);
    RST = 1'b1;
    cyc = 0;
    stepTo(16);
    applyStimulus(3'b111);
    stepTo(20);
    checkOutput("postrst0_press_count", pressCnt[0], pressBase + 1);
    checkOutput("postrst0_press_at", pressAt[0], 12);
    checkOutput("postrst0_no_release", relCnt[0], relBase);
    stepTo(32);
    checkOutput("postrst0_release_at", relAt[0], 28);

    // Simultaneous press on all channels.
    applyStimulus(3'b000);
    stepTo(43);
    checkOutput("simul_before", int'(BPRESS), 0);
    stepTo(44);
    checkOutput("simul_press", int'(BPRESS), 7);
    checkOutput("simul_level", int'(BLEVEL), 7);
    stepTo(45);
    checkOutput("simul_press_end", int'(BPRESS), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/btn_debounce_rpt.md
BTN_DEBOUNCE_RPT -- requirements
Module: btn_debounce_rpt

Interface
REQ-001 Parameter NCH, default 3, number of independent button channels (1..16).
REQ-002 Parameter DIV, default 1200000, sample-tick period in CLK cycles (>=1; 1 means a tick every cycle).
REQ-003 Parameter STABLE, default 3, consecutive differing samples needed to accept a level change (>=1).
REQ-004 Parameter LONG, default 40, held samples before the first auto-repeat (>=2).
REQ-005 Parameter RPT, default 8, samples between subsequent auto-repeats (1..LONG).
REQ-006 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-007 RST  in  1  asynchronous, active-low reset.
REQ-008 nBIN  in  NCH  raw active-low button inputs, asynchronous to CLK.
REQ-009 BLEVEL  out  NCH  debounced pressed state, 1 = pressed.
REQ-010 BPRESS  out  NCH  one-CLK pulse on an accepted press.
REQ-011 BRELEASE  out  NCH  one-CLK pulse on an accepted release.
REQ-012 BREPEAT  out  NCH  one-CLK auto-repeat pulse while held.

Function
REQ-013 Tick counter runs 0..DIV-1 and wraps; tick is high for one CLK when the count equals DIV-1.
REQ-014 Each nBIN bit passes through a two-flop synchroniser clocked every CLK, not only on ticks; sample = inverted synchroniser output.
REQ-015 Per channel, on each tick: sample equal to BLEVEL clears the stability counter; sample differing increments it.
REQ-016 When the increment brings the stability counter to STABLE, BLEVEL takes the sample value on that same edge and the counter clears.
REQ-017 BPRESS (0->1) or BRELEASE (1->0) is high for exactly the CLK cycle in which the new BLEVEL is first visible; the two are never high together on one channel.
REQ-018 Hold counter clears on every accepted press and release; it increments on each tick while BLEVEL=1.
REQ-019 When the hold counter reaches LONG, BREPEAT pulses for one CLK and the counter loads LONG-RPT, so later repeats occur every RPT ticks.
REQ-020 No BREPEAT occurs in the press cycle itself or after release; a release on a tick that would also repeat yields BRELEASE only.
REQ-021 Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-022 All outputs are registered; no combinational path from nBIN to any output.
REQ-023 Counter widths are sized from parameters with no overflow at maximum values; the stability counter never exceeds STABLE.

Reset
REQ-024 While RST=0: tick, stability and hold counters are 0; synchroniser flops are 1 (released); BLEVEL, BPRESS, BRELEASE, BREPEAT are 0.
REQ-025 A button still held at reset release is accepted as a fresh press after STABLE ticks; reset mid-hold emits no BRELEASE.

Structure
REQ-026 Shared package btn_pkg holds default parameter constants and a width function (ceiling log2) used by all counters.
REQ-027 One sub-module btn_chan holds per-channel synchroniser, stability counter, hold counter and pulse registers; the top holds the shared tick generator and instantiates NCH copies of btn_chan.

Verification (bench parameters DIV=4, STABLE=3, LONG=6, RPT=2, NCH=3)
REQ-028 Clean press: nBIN[0] driven low and held -> BLEVEL[0] rises on the 3rd tick after synchroniser latency, BPRESS[0] high for exactly 1 CLK, other channels quiet.
REQ-029 Bounce: nBIN[1] toggled every tick for 12 ticks, then high -> no BPRESS/BRELEASE/BREPEAT on channel 1, BLEVEL[1] stays 0.
REQ-030 Long hold: nBIN[2] held low 20 ticks past acceptance -> BREPEAT[2] on held ticks 6, 8, 10, 12, 14, 16, 18, 20, each 1 CLK wide.
REQ-031 Release: after the long hold, nBIN[2] high -> BRELEASE[2] 1 CLK on the 3rd tick, BLEVEL[2]=0, no further BREPEAT; a re-press needs 6 held ticks before a repeat.
REQ-032 Reset mid-hold: RST low for 2 CLK while channel 0 held -> all outputs 0 during reset, no BRELEASE; BPRESS[0] again 3 ticks after RST returns high.
REQ-033 Simultaneous: all nBIN low on the same cycle -> BPRESS[2:0]=3'b111 in one CLK cycle.
